// File: rtl/sar_search.sv
// Successive-approximation search controller: binary-searches MSB-first for the
// hidden operand of an external comparator using its one-hot g/l/e result.
module sar_search #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         g,
    input  logic         l,
    input  logic         e,
    output logic [W-1:0] trial,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         err
);

    localparam int KW = (W > 1) ? $clog2(W) : 1;
    localparam logic [W-1:0]  ONE   = W'(1);
    localparam logic [W-1:0]  MSB   = ONE << (W - 1);
    localparam logic [KW-1:0] K_TOP = KW'(W - 1);

    typedef enum logic {
        IDLE,
        TEST
    } state_t;

    state_t        state;
    logic [W-1:0]  acc;
    logic [KW-1:0] k;

    logic          hit_e;
    logic          hit_l;
    logic          hit_g;
    logic [W-1:0]  acc_new;
    logic [W-1:0]  next_trial;

    // Exactly-one decoding; any other code is treated as a comparator fault.
    always_comb begin
        hit_e      = e & ~g & ~l;
        hit_l      = l & ~g & ~e;
        hit_g      = g & ~l & ~e;
        acc_new    = hit_l ? trial : acc;
        next_trial = acc_new | (ONE << (k - 1'b1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            trial  <= '0;
            acc    <= '0;
            k      <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= TEST;
                        acc    <= '0;
                        k      <= K_TOP;
                        trial  <= MSB;
                        busy   <= 1'b1;
                        err    <= 1'b0;
                        result <= '0;
                    end else begin
                        trial <= '0;
                    end
                end
                TEST: begin
                    if (hit_e) begin
                        result <= trial;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        trial  <= '0;
                        state  <= IDLE;
                    end else if (hit_l || hit_g) begin
                        acc <= acc_new;
                        if (k != '0) begin
                            k     <= k - 1'b1;
                            trial <= next_trial;
                        end else begin
                            result <= acc_new;
                            done   <= 1'b1;
                            busy   <= 1'b0;
                            trial  <= '0;
                            state  <= IDLE;
                        end
                    end else begin
                        err    <= 1'b1;
                        result <= '0;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        trial  <= '0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    trial <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sar_search.sv
// Self-checking bench for sar_search: a behavioural comparator plus a reference
// binary search that predicts each trial, the result and the latency.
module tb_sar_search;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         g;
    logic         l;
    logic         e;
    logic [W-1:0] trial;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         err;

    logic [W-1:0] target;
    logic         bad;

    int unsigned n_tests;
    int unsigned n_fail;

    sar_search #(.W(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .g      (g),
        .l      (l),
        .e      (e),
        .trial  (trial),
        .busy   (busy),
        .done   (done),
        .result (result),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ideal comparator; 'bad' forces the illegal g=l=1 code.
    always_comb begin
        g = bad ? 1'b1 : (trial > target);
        l = bad ? 1'b1 : (trial < target);
        e = bad ? 1'b0 : (trial == target);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: ordinary binary search over the value range.
    task automatic ref_trials(input logic [W-1:0] tgt, output int unsigned cnt, output logic [W-1:0] seq [W]);
        int unsigned a;
        int unsigned t;
        a   = 0;
        cnt = 0;
        for (int b = W - 1; b >= 0; b--) begin
            t = a + (1 << b);
            seq[cnt] = W'(t);
            cnt++;
            if (t == int'(tgt)) break;
            if (t < int'(tgt)) a = t;
        end
    endtask

    task automatic run_search(input logic [W-1:0] tgt, input int unsigned fault_at,
                              input int unsigned rst_at, input bit hold_start, input bit noise);
        logic [W-1:0] seq [W];
        int unsigned  cnt;
        int unsigned  n;
        ref_trials(tgt, cnt, seq);
        target = tgt;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = hold_start;
        n = 0;
        forever begin
            if (n >= 2 * W) begin
                check("timeout", n, cnt);
                break;
            end
            if (n < cnt) check("trial", trial, seq[n]);
            else         check("overrun", n, cnt);
            check("busy_test", busy, 1);
            check("done_test", done, 0);
            check("err_test", err, 0);
            check("result_test", result, 0);
            bad   = (fault_at == n + 1);
            rst_n = !(rst_at == n + 1);
            if (noise) start = hold_start | 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            n++;
            bad   = 1'b0;
            start = hold_start;
            if (rst_at == n) begin
                rst_n = 1'b1;
                check("rst_trial", trial, 0);
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                check("rst_result", result, 0);
                return;
            end
            if (done) break;
        end
        if (fault_at != 0) begin
            check("fault_lat", n, fault_at);
            check("fault_err", err, 1);
            check("fault_result", result, 0);
        end else begin
            check("latency", n, cnt);
            check("result", result, tgt);
            check("err", err, 0);
        end
        check("end_trial", trial, 0);
        check("end_busy", busy, 0);
        if (!hold_start) begin
            @(posedge clk);
            #1;
            check("done_fall", done, 0);
            check("idle_trial", trial, 0);
            check("hold_result", result, (fault_at != 0) ? 0 : tgt);
            check("hold_err", err, (fault_at != 0) ? 1 : 0);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        start   = 1'b1;
        bad     = 1'b0;
        target  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_trial", trial, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_result", result, 0);
        check("reset_err", err, 0);
        start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_busy", busy, 0);

        run_search(8'hA5, 0, 0, 1'b0, 1'b0);
        run_search(8'h80, 0, 0, 1'b0, 1'b0);
        run_search(8'h00, 0, 0, 1'b0, 1'b0);
        run_search(8'hFF, 0, 0, 1'b0, 1'b0);
        run_search(8'hA5, 3, 0, 1'b0, 1'b0);
        run_search(8'h3C, 0, 0, 1'b0, 1'b1);
        run_search(8'h5A, 0, 0, 1'b1, 1'b0);
        run_search(8'h5A, 0, 0, 1'b1, 1'b0);
        run_search(8'h5A, 0, 0, 1'b0, 1'b0);
        run_search(8'hA5, 0, 4, 1'b0, 1'b0);
        run_search(8'hC3, 0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            run_search(W'($urandom_range(0, 255)), 0, 0, 1'b0, 1'b1);
        end
        run_search(8'h77, 1 + $urandom_range(0, 5), 0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
